// File: rtl/matrix_io_ctrl.sv
// -----------------------------------------------------------------------------
// matrix_io_ctrl
//
// Sequencing front-end for the matrix ULA. It receives two N x N signed operand
// matrices as a byte stream, assembles them onto the packed Aa/Bb buses, and
// drives the ULA opcode for a fixed latency window. It then captures the
// packed result Pp and streams the result elements out again.
//
// Element packing on Aa, Bb and Pp: element e = N*i + j sits at [e*W +: W].
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        one-cycle request; honoured only while idle
//   cmd_op       opcode, latched together with an accepted start
//   in_data      operand element (A elements 0..N*N-1, then B elements)
//   in_valid     in_data valid
//   in_ready     high while loading A or B
//   Aa, Bb       packed operands to the ULA (held until the next load)
//   op           opcode to the ULA; zero outside the execute window
//   Pp           packed ULA result
//   out_data     result element, row-major, element 0 first
//   out_valid    out_data valid
//   out_ready    downstream accepts out_data
//   busy         high whenever not idle
//   done         one-cycle pulse after the last result element is accepted
//
// Optional build macro MATRIX_IO_LAST_EN adds:
//   in_last      must be high exactly with the last B element
//   out_last     high with the last result element
//   err          sticky framing error on in_last; cleared by an accepted start
// -----------------------------------------------------------------------------
module matrix_io_ctrl #(
  parameter int N        = 5,
  parameter int W        = 8,
  parameter int EXEC_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       cmd_op,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N*N*W-1:0] Aa,
  output logic [N*N*W-1:0] Bb,
  output logic [2:0]       op,
  input  logic [N*N*W-1:0] Pp,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
`ifdef MATRIX_IO_LAST_EN
  ,
  input  logic             in_last,
  output logic             out_last,
  output logic             err
`endif
);

  localparam int NE = N * N;
  localparam int CW = (NE > 1) ? $clog2(NE) : 1;
  localparam int XW = (EXEC_LAT > 0) ? $clog2(EXEC_LAT + 1) : 1;

  localparam logic [CW-1:0] LAST_ELEM = CW'(NE - 1);
  localparam logic [XW-1:0] LAST_EXEC = XW'(EXEC_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_UNLOAD
  } state_t;

  state_t             state;
  logic [2:0]         opcode_q;
  logic [CW-1:0]      cnt;
  logic [XW-1:0]      xcnt;
  logic [N*N*W-1:0]   result_q;
  logic [CW-1:0]      cnt_inc;
  logic               in_fire;
  logic               out_fire;

  assign cnt_inc  = cnt + CW'(1);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

`ifdef MATRIX_IO_LAST_EN
  // in_last belongs only on the final B element; anything else is a framing error.
  logic last_expected;
  assign last_expected = (state == S_LOAD_B) && (cnt == LAST_ELEM);
`endif

  // NOTE: every register here, including the wide operand/result buses, is
  // cleared by the asynchronous reset so an aborted operation leaves no stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      opcode_q  <= '0;
      cnt       <= '0;
      xcnt      <= '0;
      result_q  <= '0;
      Aa        <= '0;
      Bb        <= '0;
      op        <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef MATRIX_IO_LAST_EN
      out_last  <= 1'b0;
      err       <= 1'b0;
`endif
    end else begin
      // NOTE: state updates use non-blocking assignments so every branch sees
      // the pre-edge values of cnt/state, matching the hardware.
      done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            opcode_q <= cmd_op;
            cnt      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= S_LOAD_A;
`ifdef MATRIX_IO_LAST_EN
            err      <= 1'b0;
`endif
          end
        end

        S_LOAD_A: begin
          if (in_fire) begin
            Aa[cnt*W +: W] <= in_data;
`ifdef MATRIX_IO_LAST_EN
            if (in_last != last_expected) err <= 1'b1;
`endif
            if (cnt == LAST_ELEM) begin
              cnt   <= '0;
              state <= S_LOAD_B;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end

        S_LOAD_B: begin
          if (in_fire) begin
            Bb[cnt*W +: W] <= in_data;
`ifdef MATRIX_IO_LAST_EN
            if (in_last != last_expected) err <= 1'b1;
`endif
            if (cnt == LAST_ELEM) begin
              // op is registered here so it is already on the bus in the
              // first execute cycle and stays for EXEC_LAT+1 cycles.
              cnt      <= '0;
              xcnt     <= '0;
              in_ready <= 1'b0;
              op       <= opcode_q;
              state    <= S_EXEC;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end

        S_EXEC: begin
          if (xcnt == LAST_EXEC) begin
            result_q  <= Pp;
            out_data  <= Pp[W-1:0];
            out_valid <= 1'b1;
            op        <= '0;
            xcnt      <= '0;
            cnt       <= '0;
            state     <= S_UNLOAD;
`ifdef MATRIX_IO_LAST_EN
            out_last  <= (LAST_ELEM == '0);
`endif
          end else begin
            xcnt <= xcnt + XW'(1);
          end
        end

        S_UNLOAD: begin
          if (out_fire) begin
            if (cnt == LAST_ELEM) begin
              out_valid <= 1'b0;
              out_data  <= '0;
              cnt       <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= S_IDLE;
`ifdef MATRIX_IO_LAST_EN
              out_last  <= 1'b0;
`endif
            end else begin
              cnt      <= cnt_inc;
              out_data <= result_q[cnt_inc*W +: W];
`ifdef MATRIX_IO_LAST_EN
              out_last <= (cnt_inc == LAST_ELEM);
`endif
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_matrix_io_ctrl
//
// Self-checking bench for matrix_io_ctrl (default build). A behavioural ULA
// (op 010 = saturating matrix multiply, op 001 = saturating element add,
// otherwise zero) answers one cycle after op appears. Expected result bytes
// come from the same matrix rules applied to the bench's own operand arrays.
// -----------------------------------------------------------------------------
module tb_matrix_io_ctrl;

  localparam int N  = 5;
  localparam int W  = 8;
  localparam int NE = N * N;
  localparam int EL = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [2:0]       cmd_op;
  logic [W-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [NE*W-1:0]  Aa;
  logic [NE*W-1:0]  Bb;
  logic [2:0]       op;
  logic [NE*W-1:0]  Pp = '0;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  int checks    = 0;
  int errors    = 0;
  int done_seen = 0;
  int exp_done  = 0;

  byte A_m[NE];
  byte B_m[NE];

  matrix_io_ctrl #(.N(N), .W(W), .EXEC_LAT(EL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_op(cmd_op),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .Aa(Aa), .Bb(Bb), .op(op), .Pp(Pp),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Matrix rules of the ULA, shared by the ULA stand-in and the expectation.
  function automatic void compute(input logic [2:0] o, input byte a[NE],
                                  input byte b[NE], output byte r[NE]);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int acc;
        acc = 0;
        if (o == 3'b010) begin
          for (int k = 0; k < N; k++) acc += int'(a[N*i+k]) * int'(b[N*k+j]);
        end else if (o == 3'b001) begin
          acc = int'(a[N*i+j]) + int'(b[N*i+j]);
        end
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
        r[N*i+j] = byte'(acc);
      end
    end
  endfunction

  // ULA stand-in: result registered one cycle after op/Aa/Bb are seen.
  byte ua[NE];
  byte ub[NE];
  byte ur[NE];
  logic [NE*W-1:0] pnext;
  always @(posedge clk) begin
    for (int e = 0; e < NE; e++) begin
      ua[e] = byte'(Aa[e*W +: W]);
      ub[e] = byte'(Bb[e*W +: W]);
    end
    compute(op, ua, ub, ur);
    for (int e = 0; e < NE; e++) pnext[e*W +: W] = ur[e];
    Pp <= pnext;
  end

  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_op"}, op, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_Aa"}, Aa, 0);
    chk({tag, "_Bb"}, Bb, 0);
  endtask

  // One full operation. gaps: random in_valid gaps; stall: out_ready toggles;
  // poke: start pulsed in LOAD_B and UNLOAD; abort_at>=0: reset after that
  // many B bytes. Called and returning at a negedge.
  task automatic run_op(input logic [2:0] opc, input bit gaps, input bit stall,
                        input bit poke, input int abort_at);
    byte expv[NE];
    logic [NE*W-1:0] pa;
    int idx;
    int k;
    int budget;
    compute(opc, A_m, B_m, expv);
    for (int e = 0; e < NE; e++) pa[e*W +: W] = A_m[e];

    start = 1'b1; cmd_op = opc;
    @(negedge clk);
    start = 1'b0; cmd_op = 3'b111;
    chk("busy_after_start", busy, 1);

    idx = 0; budget = 0;
    while (idx < 2*NE && budget < 1000) begin
      if (abort_at >= 0 && idx == NE + abort_at) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_idle_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      chk("in_ready_load", in_ready, 1);
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = (idx < NE) ? A_m[idx] : B_m[idx-NE];
      start    = poke && (idx == NE + 3);
      @(posedge clk);
      if (in_valid) idx++;
      @(negedge clk);
      start = 1'b0;
      budget++;
    end
    in_valid = 1'b0;
    chk("load_count", idx, 2*NE);

    for (int c = 0; c <= EL; c++) begin
      chk("op_exec", op, opc);
      chk("in_ready_exec", in_ready, 0);
      chk("out_valid_exec", out_valid, 0);
      @(negedge clk);
    end
    chk("op_after_exec", op, 0);

    k = 0; budget = 0;
    out_ready = 1'b0;
    while (k < NE && budget < 1000) begin
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, $unsigned(expv[k]));
      chk("busy_unload", busy, 1);
      out_ready = stall ? ~out_ready : 1'b1;
      start     = poke && (k == 5);
      @(posedge clk);
      if (out_ready) k++;
      @(negedge clk);
      start = 1'b0;
      budget++;
    end
    out_ready = 1'b1;
    chk("unload_count", k, NE);

    chk("done_pulse", done, 1);
    chk("busy_idle", busy, 0);
    chk("out_valid_idle", out_valid, 0);
    chk("op_idle", op, 0);
    chk("Aa_hold", Aa, pa);
    exp_done++;
    @(negedge clk);
    chk("done_single", done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; start = 1'b0; cmd_op = '0; in_data = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #3 chk_idle_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_valid_ignored", in_ready, 0);

    // Identity times 1..25.
    for (int e = 0; e < NE; e++) begin
      A_m[e] = byte'((e / N == e % N) ? 1 : 0);
      B_m[e] = byte'(e + 1);
    end
    run_op(3'b010, 0, 0, 0, -1);

    // All 2 times all 3 -> 30.
    for (int e = 0; e < NE; e++) begin A_m[e] = 2; B_m[e] = 3; end
    run_op(3'b010, 0, 0, 0, -1);

    // Positive and negative saturation.
    for (int e = 0; e < NE; e++) begin A_m[e] = 100; B_m[e] = 100; end
    run_op(3'b010, 0, 0, 0, -1);
    for (int e = 0; e < NE; e++) begin A_m[e] = -100; B_m[e] = 100; end
    run_op(3'b010, 0, 0, 0, -1);

    // Random operands with input gaps, output stalls and ignored starts.
    for (int e = 0; e < NE; e++) begin
      A_m[e] = byte'(int'($urandom_range(0, 15)) - 8);
      B_m[e] = byte'(int'($urandom_range(0, 15)) - 8);
    end
    run_op(3'b010, 1, 1, 1, -1);
    run_op(3'b010, 0, 0, 0, -1);

    // Random wide operands through the element-add opcode.
    for (int e = 0; e < NE; e++) begin
      A_m[e] = byte'($urandom_range(0, 255));
      B_m[e] = byte'($urandom_range(0, 255));
    end
    run_op(3'b001, 1, 1, 0, -1);

    // Reset after 10 B bytes, then a fresh full operation.
    run_op(3'b010, 0, 0, 0, 10);
    for (int e = 0; e < NE; e++) begin
      A_m[e] = byte'(int'($urandom_range(0, 9)) - 5);
      B_m[e] = byte'(int'($urandom_range(0, 9)) - 5);
    end
    run_op(3'b010, 1, 0, 0, -1);

    @(negedge clk);
    chk("done_count", done_seen, exp_done);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_io_ctrl.md
Name: matrix_io_ctrl

Overview:
- Sequencing front-end for the matrix ULA.
- Receives the two 5x5 signed 8-bit operand matrices as a byte stream (valid/ready) and assembles them onto the 200-bit Aa/Bb buses.
- Drives the ULA opcode for a fixed latency window, captures the 200-bit result Pp, then streams the 25 result bytes out over a second valid/ready port.
- Sits directly upstream and downstream of the matrix multiplier/ULA stage.

Parameters:
N, 5, matrix dimension (N x N elements); ports sized for N*N*W bits.
W, 8, element width in bits (two's complement).
EXEC_LAT, 1, cycles from op first visible to Pp valid at the ULA output.

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
start  in  1  one-cycle request to begin a new operation; honoured only in IDLE
cmd_op  in  3  opcode to run, sampled together with an accepted start
in_data  in  8  operand element
in_valid  in  1  in_data valid
in_ready  out  1  high only in LOAD_A/LOAD_B
Aa  out  200  operand A to ULA, element e=N*i+j at bits [e*W +: W]
Bb  out  200  operand B to ULA, same packing
op  out  3  opcode to ULA; 3'b000 outside EXEC
Pp  in  200  ULA result, same packing
out_data  out  8  result element
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last result byte is accepted

Behaviour:
- Reset (rst_n low, async): state=IDLE, Aa=Bb=0, op=0, result register=0, element counter=0, in_ready=out_valid=busy=done=0, out_data=0. Reset mid-operation aborts and discards all partial data.
- IDLE:
  - start=1: latch cmd_op, counter=0, go to LOAD_A.
  - in_valid is ignored because in_ready=0; start and in_valid in the same cycle take start only.
- LOAD_A:
  - On in_valid&&in_ready: write in_data to Aa element counter. Elements are row-major, element 0 first.
  - counter++. After element 24 is accepted: counter=0, go to LOAD_B.
- LOAD_B: identical to LOAD_A but writes Bb. After element 24 is accepted: go to EXEC with exec counter=0.
- EXEC:
  - op=latched opcode (registered, so first visible the cycle after entry); in_ready=0.
  - Exec counter increments every cycle. On the edge ending the cycle where counter==EXEC_LAT: capture Pp into the result register, op returns to 0 next cycle, counter=0, go to UNLOAD.
  - With EXEC_LAT=1: op is visible for exactly 2 cycles.
- UNLOAD:
  - out_valid=1; out_data=result element counter (registered, stable while out_ready=0).
  - On out_valid&&out_ready: counter++. After element 24 is accepted: out_valid=0, done=1 for one cycle, go to IDLE.
- start asserted while busy: ignored, not queued.
- Aa/Bb hold their values after completion until overwritten by the next load. The result register holds until the next capture.
- No arithmetic is performed here; result bytes are passed through unchanged (saturation is the ULA's job).
- Throughput: one byte per cycle in each direction with no bubbles when valid/ready are held high. Minimum operation time is 1 + 50 + (EXEC_LAT+1) + 25 cycles.

Optional Feature:
MATRIX_IO_LAST_EN:
- Defined:
  - Adds ports in_last (in, 1), out_last (out, 1) and err (out, 1).
  - out_last is high with result element 24.
  - in_last must be high exactly with B element 24. A mismatch (early in_last, or missing at element 24) sets sticky err. Loading still completes on the count.
  - err clears when start is accepted and on reset.
- Undefined: these ports are absent and the stream is delimited by count only.

Test Plan:
- A=identity (diag 1, rest 0), B elements 0..24 = 1..25, cmd_op=010 -> op=010 for 2 cycles, then out bytes 1..25 in order, done pulse, op back to 000.
- A all 2, B all 3, op=010 -> 25 output bytes, each 30 (0x1E).
- A all 100, B all 100, ULA saturating -> all 25 outputs 127. Also: A all -100, B all 100 -> all -128 (0x80).
- out_ready toggled 1/0 every cycle, in_valid with random gaps -> data identical to the unstalled run, out_data stable while stalled, busy high throughout.
- rst_n pulsed low after 10 B bytes -> immediate IDLE, all outputs 0. A fresh full operation then produces correct results.
- start pulsed during LOAD_B and during UNLOAD -> ignored, no extra done. With MATRIX_IO_LAST_EN: in_last on B element 20 -> err=1 and the run still completes; err=0 after the next start.
